// File: rtl/mem_stage_ctrl.sv
// Data-memory stage of the multicycle ARM core: LDR/STR word/byte accesses against a
// synchronous single-port RAM (read-modify-write for byte stores), then Rd/Rn writeback.
module mem_stage_ctrl #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_mem,
    input  logic              load_store,
    input  logic              byte_word,
    input  logic              pre_post,
    input  logic              write_back,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       base_addr,
    input  logic [31:0]       store_data,
    input  logic [3:0]        rd_in,
    input  logic [3:0]        rn_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        wb_rd,
    output logic              wb_rd_en,
    output logic [31:0]       wb_data,
    output logic [3:0]        wb_rn,
    output logic              wb_rn_en,
    output logic [31:0]       wb_base,
    output logic              addr_fault
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_WRITE, S_RESP} state_t;

    state_t state_q, state_d;

    logic              mem_q, ld_q, byte_q, pre_q, wbk_q, fault_q;
    logic              mem_d, ld_d, byte_d, pre_d, wbk_d, fault_d;
    logic [31:0]       alu_q, sdata_q, data_q;
    logic [31:0]       alu_d, sdata_d, data_d;
    logic [3:0]        rd_q, rn_q, rd_d, rn_d;
    logic [ADDR_W+1:0] ea_q, ea_d;

    logic              accept;
    logic [ADDR_W+1:0] ea_in;
    logic              fault_in;
    logic              unused_base_hi;

    function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [7:0] b,
                                               input logic [1:0] lane);
        logic [31:0] m;
        m = w;
        case (lane)
            2'd0:    m[7:0]   = b;
            2'd1:    m[15:8]  = b;
            2'd2:    m[23:16] = b;
            default: m[31:24] = b;
        endcase
        return m;
    endfunction

    // Only the RAM-visible address bits are kept, so high address bits wrap.
    assign accept         = in_valid & in_ready;
    assign ea_in          = pre_post ? alu_result[ADDR_W+1:0] : base_addr[ADDR_W+1:0];
    assign fault_in       = is_mem & ~byte_word & (ea_in[1:0] != 2'b00);
    assign unused_base_hi = ^base_addr[31:ADDR_W+2];

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!is_mem || fault_in)       state_d = S_RESP;
                    else if (load_store || byte_word) state_d = S_READ;
                    else                           state_d = S_WRITE;
                end
            end
            S_READ:  state_d = S_CAPT;
            S_CAPT:  state_d = ld_q ? S_RESP : S_WRITE;
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Captured instruction fields; only state is reset, outputs are gated by state.
    always_comb begin
        mem_d   = mem_q;
        ld_d    = ld_q;
        byte_d  = byte_q;
        pre_d   = pre_q;
        wbk_d   = wbk_q;
        fault_d = fault_q;
        alu_d   = alu_q;
        sdata_d = sdata_q;
        data_d  = data_q;
        rd_d    = rd_q;
        rn_d    = rn_q;
        ea_d    = ea_q;
        if (accept) begin
            mem_d   = is_mem;
            ld_d    = load_store;
            byte_d  = byte_word;
            pre_d   = pre_post;
            wbk_d   = write_back;
            fault_d = fault_in;
            alu_d   = alu_result;
            sdata_d = store_data;
            data_d  = alu_result;
            rd_d    = rd_in;
            rn_d    = rn_in;
            ea_d    = ea_in;
        end else if (state_q == S_CAPT) begin
            if (ld_q)
                data_d = byte_q ? {24'd0, byte_lane(ram_rdata, ea_q[1:0])} : ram_rdata;
            else
                data_d = merge_lane(ram_rdata, sdata_q[7:0], ea_q[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        mem_q   <= mem_d;
        ld_q    <= ld_d;
        byte_q  <= byte_d;
        pre_q   <= pre_d;
        wbk_q   <= wbk_d;
        fault_q <= fault_d;
        alu_q   <= alu_d;
        sdata_q <= sdata_d;
        data_q  <= data_d;
        rd_q    <= rd_d;
        rn_q    <= rn_d;
        ea_q    <= ea_d;
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE) & ~nreset;
        ram_re     = (state_q == S_READ) & ~nreset;
        ram_we     = (state_q == S_WRITE) & ~nreset;
        ram_addr   = '0;
        ram_wdata  = '0;
        out_valid  = 1'b0;
        addr_fault = 1'b0;
        wb_rd      = '0;
        wb_rn      = '0;
        wb_rd_en   = 1'b0;
        wb_rn_en   = 1'b0;
        wb_data    = '0;
        wb_base    = '0;
        if (state_q == S_READ || state_q == S_WRITE)
            ram_addr = ea_q[ADDR_W+1:2];
        if (state_q == S_WRITE)
            ram_wdata = byte_q ? data_q : sdata_q;
        if (state_q == S_RESP) begin
            out_valid  = 1'b1;
            addr_fault = fault_q;
            wb_rd      = rd_q;
            wb_rn      = rn_q;
            wb_rd_en   = ~fault_q & (~mem_q | ld_q);
            wb_rn_en   = mem_q & ~fault_q & (~pre_q | wbk_q);
            wb_data    = (~fault_q & (~mem_q | ld_q)) ? data_q : 32'd0;
            wb_base    = (mem_q & ~fault_q) ? alu_q : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a behavioural synchronous data RAM.
module tb_mem_stage_ctrl;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              nreset;
    logic              in_valid, in_ready;
    logic              is_mem, load_store, byte_word, pre_post, write_back;
    logic [31:0]       alu_result, base_addr, store_data;
    logic [3:0]        rd_in, rn_in;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re, ram_we;
    logic [31:0]       ram_wdata, ram_rdata;
    logic              out_valid, out_ready;
    logic [3:0]        wb_rd, wb_rn;
    logic              wb_rd_en, wb_rn_en, addr_fault;
    logic [31:0]       wb_data, wb_base;

    logic [31:0]       mem [0:63];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [31:0]       pre_data = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int lat, re_cyc, we_cyc;
    logic [31:0]       we_data;
    logic [ADDR_W-1:0] we_addr, re_addr;

    mem_stage_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
        .is_mem(is_mem), .load_store(load_store), .byte_word(byte_word),
        .pre_post(pre_post), .write_back(write_back), .alu_result(alu_result),
        .base_addr(base_addr), .store_data(store_data), .rd_in(rd_in), .rn_in(rn_in),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .wb_rd(wb_rd), .wb_rd_en(wb_rd_en), .wb_data(wb_data), .wb_rn(wb_rn),
        .wb_rn_en(wb_rn_en), .wb_base(wb_base), .addr_fault(addr_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic m, input logic l, input logic b, input logic p,
                         input logic w, input logic [31:0] alu, input logic [31:0] base,
                         input logic [31:0] sd, input logic [3:0] rd, input logic [3:0] rn);
        @(negedge clk);
        is_mem = m; load_store = l; byte_word = b; pre_post = p; write_back = w;
        alu_result = alu; base_addr = base; store_data = sd; rd_in = rd; rn_in = rn;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called in cycle 1 after the accept edge; records RAM strobes and latency.
    task automatic run_until_valid();
        lat = 1; re_cyc = 0; we_cyc = 0;
        while (1) begin
            if (ram_re === 1'b1 && re_cyc == 0) begin re_cyc = lat; re_addr = ram_addr; end
            if (ram_we === 1'b1 && we_cyc == 0) begin
                we_cyc = lat; we_addr = ram_addr; we_data = ram_wdata;
            end
            if (out_valid === 1'b1 || lat >= 20) break;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_tests++; if ({out_valid, ram_re, ram_we, wb_rd_en, wb_rn_en, addr_fault} !== 6'b0) begin
            n_fail++; $display("FAIL rst_ctrl_outs: got %b want 000000", {out_valid, ram_re, ram_we, wb_rd_en, wb_rn_en, addr_fault}); end
        n_tests++; if ({wb_data, wb_base, ram_wdata} !== 96'd0) begin
            n_fail++; $display("FAIL rst_data_outs: got %h %h %h want 0", wb_data, wb_base, ram_wdata); end
        @(negedge clk); nreset = 1'b0; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_non_mem();
        issue(0, 0, 0, 0, 0, 32'h1234_5678, 32'h0, 32'h0, 4'd3, 4'd7);
        run_until_valid();
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL nonmem_lat: got %0d want 1", lat); end
        n_tests++; if (wb_data !== 32'h1234_5678) begin n_fail++; $display("FAIL nonmem_data: got %h want 12345678", wb_data); end
        n_tests++; if ({wb_rd, wb_rd_en, wb_rn_en, addr_fault} !== {4'd3, 3'b100}) begin
            n_fail++; $display("FAIL nonmem_fields: got rd=%0d rd_en=%b rn_en=%b flt=%b want 3 1 0 0", wb_rd, wb_rd_en, wb_rn_en, addr_fault); end
        n_tests++; if (re_cyc != 0 || we_cyc != 0) begin n_fail++; $display("FAIL nonmem_ram: got re=%0d we=%0d want 0 0", re_cyc, we_cyc); end
        @(posedge clk); #1;
        n_tests++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL nonmem_return: got %b want 10", {in_ready, out_valid}); end
    endtask

    task automatic test_word_load();
        poke(6'd5, 32'hDEAD_BEEF);
        issue(1, 1, 0, 1, 1, 32'h14, 32'h10, 32'h0, 4'd2, 4'd2);
        run_until_valid();
        n_tests++; if (re_cyc !== 1 || re_addr !== 6'd5) begin n_fail++; $display("FAIL wld_read: got cyc=%0d addr=%0d want 1 5", re_cyc, re_addr); end
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL wld_lat: got %0d want 3", lat); end
        n_tests++; if (wb_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wld_data: got %h want deadbeef", wb_data); end
        n_tests++; if ({wb_base, wb_rd_en, wb_rn_en, wb_rd, wb_rn} !== {32'h14, 2'b11, 4'd2, 4'd2}) begin
            n_fail++; $display("FAIL wld_wb: got base=%h rd_en=%b rn_en=%b rd=%0d rn=%0d want 14 1 1 2 2", wb_base, wb_rd_en, wb_rn_en, wb_rd, wb_rn); end
        n_tests++; if (we_cyc != 0) begin n_fail++; $display("FAIL wld_no_write: got we at %0d want none", we_cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_store();
        poke(6'd2, 32'h1122_3344);
        issue(1, 0, 1, 0, 0, 32'h0E, 32'h0A, 32'h0000_00FF, 4'd5, 4'd4);
        run_until_valid();
        n_tests++; if (re_cyc !== 1 || re_addr !== 6'd2) begin n_fail++; $display("FAIL bst_read: got cyc=%0d addr=%0d want 1 2", re_cyc, re_addr); end
        n_tests++; if (we_cyc !== 3 || we_addr !== 6'd2) begin n_fail++; $display("FAIL bst_write: got cyc=%0d addr=%0d want 3 2", we_cyc, we_addr); end
        n_tests++; if (we_data !== 32'h11FF_3344) begin n_fail++; $display("FAIL bst_wdata: got %h want 11ff3344", we_data); end
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL bst_lat: got %0d want 4", lat); end
        n_tests++; if ({wb_base, wb_rd_en, wb_rn_en, addr_fault} !== {32'h0E, 3'b010}) begin
            n_fail++; $display("FAIL bst_wb: got base=%h rd_en=%b rn_en=%b flt=%b want e 0 1 0", wb_base, wb_rd_en, wb_rn_en, addr_fault); end
        n_tests++; if (mem[2] !== 32'h11FF_3344) begin n_fail++; $display("FAIL bst_ram: got %h want 11ff3344", mem[2]); end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_load();
        poke(6'd3, 32'h8000_0000);
        issue(1, 1, 1, 0, 0, 32'h10, 32'h0000_010F, 32'h0, 4'd6, 4'd1);
        run_until_valid();
        n_tests++; if (re_addr !== 6'd3) begin n_fail++; $display("FAIL bld_wrap_addr: got %0d want 3", re_addr); end
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL bld_lat: got %0d want 3", lat); end
        n_tests++; if (wb_data !== 32'h0000_0080) begin n_fail++; $display("FAIL bld_data: got %h want 00000080", wb_data); end
        n_tests++; if ({wb_base, wb_rd_en, wb_rn_en} !== {32'h10, 2'b11}) begin
            n_fail++; $display("FAIL bld_wb: got base=%h rd_en=%b rn_en=%b want 10 1 1", wb_base, wb_rd_en, wb_rn_en); end
        @(posedge clk); #1;
    endtask

    task automatic test_word_store();
        issue(1, 0, 0, 1, 0, 32'h20, 32'h1C, 32'hCAFE_F00D, 4'd0, 4'd1);
        run_until_valid();
        n_tests++; if (we_cyc !== 1 || we_addr !== 6'd8 || we_data !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL wst_write: got cyc=%0d addr=%0d data=%h want 1 8 cafef00d", we_cyc, we_addr, we_data); end
        n_tests++; if (re_cyc != 0) begin n_fail++; $display("FAIL wst_no_read: got re at %0d want none", re_cyc); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL wst_lat: got %0d want 2", lat); end
        n_tests++; if ({wb_base, wb_rd_en, wb_rn_en} !== {32'h20, 2'b00}) begin
            n_fail++; $display("FAIL wst_wb: got base=%h rd_en=%b rn_en=%b want 20 0 0", wb_base, wb_rd_en, wb_rn_en); end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned();
        issue(1, 0, 0, 1, 1, 32'h06, 32'h02, 32'h55, 4'd1, 4'd2);
        run_until_valid();
        n_tests++; if (re_cyc != 0 || we_cyc != 0) begin n_fail++; $display("FAIL mis_ram: got re=%0d we=%0d want 0 0", re_cyc, we_cyc); end
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL mis_lat: got %0d want 1", lat); end
        n_tests++; if ({addr_fault, wb_rd_en, wb_rn_en} !== 3'b100) begin
            n_fail++; $display("FAIL mis_fields: got flt=%b rd_en=%b rn_en=%b want 1 0 0", addr_fault, wb_rd_en, wb_rn_en); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure_reset();
        out_ready = 1'b0;
        poke(6'd9, 32'hA5A5_5A5A);
        issue(1, 1, 0, 1, 0, 32'h24, 32'h20, 32'h0, 4'd8, 4'd9);
        run_until_valid();
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL bp_lat: got %0d want 3", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++; if ({out_valid, in_ready, wb_rd_en, wb_rd, wb_data} !== {3'b101, 4'd8, 32'hA5A5_5A5A}) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b rdy=%b en=%b rd=%0d data=%h want 1 0 1 8 a5a55a5a",
                                   i, out_valid, in_ready, wb_rd_en, wb_rd, wb_data); end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release: got %b want 10", {in_ready, out_valid}); end

        poke(6'd12, 32'h0102_0304);
        issue(1, 0, 1, 1, 0, 32'h30, 32'h2C, 32'h0000_00EE, 4'd0, 4'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        #1;
        n_tests++; if ({in_ready, out_valid, ram_re, ram_we, wb_rn_en, addr_fault} !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_ctrl: got %b want 000000", {in_ready, out_valid, ram_re, ram_we, wb_rn_en, addr_fault}); end
        n_tests++; if ({ram_addr, ram_wdata, wb_base} !== {6'd0, 64'd0}) begin
            n_fail++; $display("FAIL rstmid_data: got addr=%0d wdata=%h base=%h want 0", ram_addr, ram_wdata, wb_base); end
        @(posedge clk);
        @(negedge clk); nreset = 1'b0; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (mem[12] !== 32'h0102_0304) begin n_fail++; $display("FAIL rstmid_no_write: got %h want 01020304", mem[12]); end
    endtask

    initial begin
        nreset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        is_mem = 1'b0; load_store = 1'b0; byte_word = 1'b0; pre_post = 1'b0; write_back = 1'b0;
        alu_result = '0; base_addr = '0; store_data = '0; rd_in = '0; rn_in = '0;
        test_reset();
        test_non_mem();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_word_store();
        test_misaligned();
        test_backpressure_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Data-memory stage of the multicycle ARM core. It sits directly downstream of the execute stage and upstream of writeback. It accepts one executed instruction per handshake and performs LDR/STR word or byte accesses against a synchronous single-port data RAM, using read-modify-write for byte stores. It then presents the register-writeback result, including base-register writeback for pre-/post-indexed forms, to the writeback stage.

## Interface
- ADDR_W, 6, word-address width of the data RAM (64 words); effective-address bits above ADDR_W+1 are ignored (address wraps).
- clk  in  1  clock; all state changes on rising edge.
- nreset  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept; 1 only in IDLE with nreset low.
- is_mem  in  1  1 = LDR/STR, 0 = non-memory pass-through.
- load_store  in  1  L bit: 1 = load, 0 = store.
- byte_word  in  1  B bit: 1 = byte, 0 = word.
- pre_post  in  1  P bit: 1 = pre-index, 0 = post-index.
- write_back  in  1  W bit.
- alu_result  in  32  ALU output (base ± offset, or data result for non-memory).
- base_addr  in  32  Rn value.
- store_data  in  32  Rd value for stores.
- rd_in, rn_in  in  4 each  destination and base register numbers.
- ram_addr  out  ADDR_W  word address.
- ram_re  out  1  read strobe; ram_rdata valid the following cycle.
- ram_we  out  1  full-word write strobe.
- ram_wdata  out  32  write data.
- ram_rdata  in  32  read data.
- out_valid  out  1  result presented to writeback.
- out_ready  in  1  writeback accepts.
- wb_rd, wb_rd_en, wb_data  out  4/1/32  Rd writeback.
- wb_rn, wb_rn_en, wb_base  out  4/1/32  base-register writeback.
- addr_fault  out  1  qualifies out_valid: misaligned word access, no RAM activity.

## Operation
- FSM states: IDLE, READ, CAPT, WRITE, RESP. All outputs are Moore functions of state and captured registers.
- IDLE: on in_valid & in_ready, capture all inputs and compute ea = pre_post ? alu_result : base_addr.
  - Non-memory instruction: go to RESP.
  - Word access with ea[1:0] ≠ 0: go to RESP with fault set.
  - Load, or byte store: go to READ.
  - Word store: go to WRITE.
- READ: ram_re=1, ram_addr=ea[ADDR_W+1:2]; next state CAPT.
- CAPT: sample ram_rdata. Byte lanes are little-endian; lane = ea[1:0].
  - Byte load: data = zero-extended ram_rdata[8*lane+:8]; next state RESP.
  - Word load: data = ram_rdata; next state RESP.
  - Byte store: merged = ram_rdata with the lane replaced by store_data[7:0]; next state WRITE.
- WRITE: ram_we=1, ram_addr=ea word, ram_wdata = merged (byte) or store_data (word); next state RESP.
- RESP: out_valid=1; hold all wb_* outputs stable until out_ready; then go to IDLE.
- Result fields:
  - Non-memory: wb_data=alu_result, wb_rd_en=1, wb_rn_en=0.
  - Load: wb_data = loaded value, wb_rd_en=1.
  - Store: wb_rd_en=0.
  - Memory, no fault: wb_base=alu_result, wb_rn_en = ~pre_post | write_back.
  - Fault: addr_fault=1, wb_rd_en=0, wb_rn_en=0.
- If rd_in == rn_in and both enables are set, both are reported. Writeback gives Rd priority.

## Timing
- Accept at cycle 0 (handshake edge). out_valid first asserts at:
  - Non-memory or fault: cycle 1.
  - Load: cycle 3 (READ c1, CAPT c2).
  - Word store: cycle 2.
  - Byte store: cycle 4.
- One instruction in flight; in_ready=0 from the accept edge until RESP completes.
- If out_ready is already 1 on RESP entry, the stage returns to IDLE after a single RESP cycle and in_ready=1 the next cycle.
- Reset values: state IDLE, in_ready 0 while nreset=1, and every other output 0. ram_we and ram_re drop asynchronously on nreset.
- Reset mid-operation discards the in-flight instruction, including a pending RMW write. in_ready is 1 in the first cycle after nreset deasserts.

## Test plan
- Non-memory: alu_result=0x1234_5678, rd_in=3 -> out_valid at cycle 1, wb_data=0x12345678, wb_rd=3, wb_rd_en=1, wb_rn_en=0.
- Word load, pre-index with W: RAM[5]=0xDEAD_BEEF, alu_result=0x14, pre_post=1, write_back=1, rn_in=2 -> ram_re at c1, out_valid at c3, wb_data=0xDEADBEEF, wb_base=0x14, wb_rn_en=1.
- Byte store, post-index: RAM[2]=0x1122_3344, base_addr=0x0A, alu_result=0x0E, store_data=0xFF -> ram_we at c3, ram_wdata=0x11FF_3344, out_valid at c4, wb_rn_en=1, wb_base=0x0E.
- Byte load from lane 3 of 0x8000_0000 -> wb_data=0x0000_0080.
- Misaligned word store at ea=0x06 -> no ram_re/ram_we, out_valid at c1, addr_fault=1, both enables 0.
- Backpressure then reset: hold out_ready=0 for 5 cycles -> outputs stable. Then assert nreset mid-byte-store at CAPT -> no ram_we, all outputs 0, in_ready=1 one cycle after release.
